// File: rtl/alu_ccr_writeback_if.sv
// Issue-side, CCR and register-file writeback signals of alu_ccr_writeback.
// The master modport is the environment (issue stage + register file); slave is the block.
interface alu_ccr_writeback_if #(
    parameter int N     = 32,
    parameter int DEPTH = 4,
    parameter int REG_W = 4
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     in_RES;
    logic [4:0]       in_XNZVC;
    logic [4:0]       in_MASK;
    logic             in_WEN;
    logic [REG_W-1:0] in_DEST;
    logic             ccr_load;
    logic [4:0]       ccr_value;
    logic [4:0]       out_CCR;
    logic             out_X;
    logic             wb_valid;
    logic             wb_ready;
    logic [N-1:0]     wb_data;
    logic [REG_W-1:0] wb_dest;
    logic [LW-1:0]    level;

    modport master (
        output in_valid, in_RES, in_XNZVC, in_MASK, in_WEN, in_DEST,
        output ccr_load, ccr_value, wb_ready,
        input  in_ready, out_CCR, out_X, wb_valid, wb_data, wb_dest, level
    );

    modport slave (
        input  in_valid, in_RES, in_XNZVC, in_MASK, in_WEN, in_DEST,
        input  ccr_load, ccr_value, wb_ready,
        output in_ready, out_CCR, out_X, wb_valid, wb_data, wb_dest, level
    );
endinterface

// File: rtl/alu_ccr_writeback.sv
// ALU writeback: masked CCR merge with X feedback, plus a result FIFO to the register file.
// Define ALU_WB_BYPASS_EN to let a result skip the empty FIFO straight to wb_* in the same cycle.
module alu_ccr_writeback #(
    parameter int N     = 32,
    parameter int DEPTH = 4,
    parameter int REG_W = 4
) (
    input logic              clk,
    input logic              reset,
    alu_ccr_writeback_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL = LW'(DEPTH);

    logic [4:0]       ccr;
    logic [N-1:0]     data_mem [DEPTH];
    logic [REG_W-1:0] dest_mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LW-1:0]    count;
    logic             acc;
    logic             push;
    logic             pop;
    logic             fifo_valid;
    logic             bypass;

    // in_ready depends only on occupancy and reset, never on wb_ready.
    assign bus.in_ready = ~reset & (count != FULL);
    assign acc          = bus.in_valid & bus.in_ready;
    assign fifo_valid   = (count != '0);

`ifdef ALU_WB_BYPASS_EN
    assign bypass = ~fifo_valid & bus.wb_ready & acc & bus.in_WEN;
`else
    assign bypass = 1'b0;
`endif

    assign push = acc & bus.in_WEN & ~bypass;
    assign pop  = fifo_valid & bus.wb_ready;

    // NOTE: every output is given a default before any conditional override, so no latch is inferred.
    always_comb begin
        bus.wb_valid = fifo_valid;
        bus.wb_data  = fifo_valid ? data_mem[rd_ptr] : '0;
        bus.wb_dest  = fifo_valid ? dest_mem[rd_ptr] : '0;
`ifdef ALU_WB_BYPASS_EN
        if (bypass) begin
            bus.wb_valid = 1'b1;
            bus.wb_data  = bus.in_RES;
            bus.wb_dest  = bus.in_DEST;
        end
`endif
    end

    // NOTE: state uses non-blocking assignments so all flops sample pre-edge values together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ccr <= 5'b00000;
        end else if (bus.ccr_load) begin
            ccr <= bus.ccr_value;
        end else if (acc) begin
            ccr <= (ccr & ~bus.in_MASK) | (bus.in_XNZVC & bus.in_MASK);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push & ~pop) begin
                count <= count + LW'(1);
            end else if (pop & ~push) begin
                count <= count - LW'(1);
            end
        end
    end

    // NOTE: storage is not reset; emptiness is tracked by count, so stale entries are never visible.
    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr] <= bus.in_RES;
            dest_mem[wr_ptr] <= bus.in_DEST;
        end
    end

    assign bus.out_CCR = ccr;
    assign bus.out_X   = ccr[4];
    assign bus.level   = count;
endmodule

// File: tb/tb_alu_ccr_writeback.sv
// Self-checking bench for alu_ccr_writeback: directed vector table, corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_alu_ccr_writeback;
    localparam int N     = 32;
    localparam int DEPTH = 4;
    localparam int REG_W = 4;
`ifdef ALU_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    alu_ccr_writeback_if #(.N(N), .DEPTH(DEPTH), .REG_W(REG_W)) bus ();
    alu_ccr_writeback #(.N(N), .DEPTH(DEPTH), .REG_W(REG_W)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [N-1:0] res, input logic [4:0] f,
                         input logic [4:0] m, input logic wen, input logic [REG_W-1:0] d,
                         input logic ld, input logic [4:0] lv, input logic wr);
        bus.in_valid  = v;
        bus.in_RES    = res;
        bus.in_XNZVC  = f;
        bus.in_MASK   = m;
        bus.in_WEN    = wen;
        bus.in_DEST   = d;
        bus.ccr_load  = ld;
        bus.ccr_value = lv;
        bus.wb_ready  = wr;
    endtask

    typedef struct {
        logic             v;
        logic [N-1:0]     res;
        logic [4:0]       f;
        logic [4:0]       m;
        logic             wen;
        logic [REG_W-1:0] d;
        logic             ld;
        logic [4:0]       lv;
        logic             wr;
        logic [4:0]       e_ccr;
        logic             e_wbv;
        logic [N-1:0]     e_data;
        logic [REG_W-1:0] e_dest;
        logic [2:0]       e_level;
    } vec_t;

    typedef struct {
        logic [N-1:0]     data;
        logic [REG_W-1:0] dest;
    } entry_t;

    vec_t        vecs[7];
    entry_t      model_q[$];
    logic [4:0]  m_ccr;
    logic [N-1:0] popped[5];
    int          got;
    bit          sent;
    bit          m_acc;
    bit          m_byp;

    initial begin
        // inputs -> registered outputs observed after the edge
        vecs[0] = '{1'b0, 32'h0, 5'b00000, 5'b00000, 1'b0, 4'd0, 1'b0, 5'b00000, 1'b1,
                    5'b00000, 1'b0, 32'h0, 4'd0, 3'd0};
        vecs[1] = '{1'b1, 32'h8FF, 5'b10001, 5'b11111, 1'b1, 4'd3, 1'b0, 5'b00000, 1'b1,
                    5'b10001, !BYP, 32'h8FF, 4'd3, BYP ? 3'd0 : 3'd1};
        vecs[2] = '{1'b0, 32'h0, 5'b00000, 5'b00000, 1'b0, 4'd0, 1'b0, 5'b00000, 1'b1,
                    5'b10001, 1'b0, 32'h0, 4'd0, 3'd0};
        vecs[3] = '{1'b1, 32'h0, 5'b00100, 5'b01111, 1'b0, 4'd0, 1'b0, 5'b00000, 1'b1,
                    5'b10100, 1'b0, 32'h0, 4'd0, 3'd0};
        vecs[4] = '{1'b1, 32'h1234, 5'b11111, 5'b11111, 1'b1, 4'd7, 1'b1, 5'b01010, 1'b0,
                    5'b01010, 1'b1, 32'h1234, 4'd7, 3'd1};
        vecs[5] = '{1'b0, 32'h0, 5'b00000, 5'b00000, 1'b0, 4'd0, 1'b0, 5'b00000, 1'b1,
                    5'b01010, 1'b0, 32'h0, 4'd0, 3'd0};
        vecs[6] = '{1'b1, 32'h55, 5'b11111, 5'b00000, 1'b0, 4'd0, 1'b0, 5'b00000, 1'b1,
                    5'b01010, 1'b0, 32'h0, 4'd0, 3'd0};

        reset = 1'b1;
        drive(0, '0, '0, '0, 0, '0, 0, '0, 1);
        #1;
        check("rst_in_ready", bus.in_ready, 1'b0);
        check("rst_level", bus.level, 3'd0);
        check("rst_wb_valid", bus.wb_valid, 1'b0);
        check("rst_ccr", bus.out_CCR, 5'b00000);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("post_rst_in_ready", bus.in_ready, 1'b1);
        check("post_rst_out_x", bus.out_X, 1'b0);

        // directed vector table
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            drive(vecs[i].v, vecs[i].res, vecs[i].f, vecs[i].m, vecs[i].wen, vecs[i].d,
                  vecs[i].ld, vecs[i].lv, vecs[i].wr);
            @(posedge clk);
            #1;
            bus.in_valid = 1'b0;
            bus.ccr_load = 1'b0;
            #1;
            check($sformatf("vec%0d_ccr", i), bus.out_CCR, vecs[i].e_ccr);
            check($sformatf("vec%0d_out_x", i), bus.out_X, vecs[i].e_ccr[4]);
            check($sformatf("vec%0d_wb_valid", i), bus.wb_valid, vecs[i].e_wbv);
            check($sformatf("vec%0d_level", i), bus.level, vecs[i].e_level);
            check($sformatf("vec%0d_in_ready", i), bus.in_ready, 1'b1);
            if (vecs[i].e_wbv) begin
                check($sformatf("vec%0d_wb_data", i), bus.wb_data, vecs[i].e_data);
                check($sformatf("vec%0d_wb_dest", i), bus.wb_dest, vecs[i].e_dest);
            end
        end

        // fill to full with the register file stalled, then drain in order
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            drive(1, N'(i), '0, '0, 1, REG_W'(i), 0, '0, 0);
            #1;
            check($sformatf("fill%0d_in_ready", i), bus.in_ready, 1'b1);
        end
        @(negedge clk);
        drive(1, N'(5), '0, '0, 1, REG_W'(5), 0, '0, 0);
        #1;
        check("full_level", bus.level, 3'd4);
        check("full_in_ready", bus.in_ready, 1'b0);
        @(posedge clk);
        #1;
        check("full_hold_level", bus.level, 3'd4);
        @(negedge clk);
        bus.wb_ready = 1'b1;
        got  = 0;
        sent = 1'b0;
        for (int c = 0; c < 20 && got < 5; c++) begin
            #1;
            if (bus.wb_valid) begin
                popped[got] = bus.wb_data;
                got++;
            end
            if (bus.in_valid && bus.in_ready) sent = 1'b1;
            @(posedge clk);
            #1;
            if (sent) bus.in_valid = 1'b0;
            @(negedge clk);
        end
        check("drain_count", got, 5);
        check("fifth_accepted", sent, 1'b1);
        for (int k = 0; k < got; k++) check($sformatf("drain_order%0d", k), popped[k], N'(k + 1));
        #1;
        check("drain_level", bus.level, 3'd0);

        // asynchronous reset with entries queued
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive(1, N'(32'hA0 + i), 5'b00110, (i == 0) ? 5'b11111 : 5'b00000, 1, REG_W'(i), 0, '0, 0);
        end
        @(negedge clk);
        drive(0, '0, '0, '0, 0, '0, 0, '0, 0);
        #1;
        check("pre_rst_level", bus.level, 3'd3);
        check("pre_rst_ccr", bus.out_CCR, 5'b00110);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_wb_valid", bus.wb_valid, 1'b0);
        check("async_rst_level", bus.level, 3'd0);
        check("async_rst_ccr", bus.out_CCR, 5'b00000);
        check("async_rst_in_ready", bus.in_ready, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        drive(0, '0, '0, '0, 0, '0, 0, '0, 1);
        #1;
        check("after_rst_in_ready", bus.in_ready, 1'b1);
        check("after_rst_wb_valid", bus.wb_valid, 1'b0);

`ifdef ALU_WB_BYPASS_EN
        @(negedge clk);
        drive(1, 32'hDEAD, '0, '0, 1, 4'd2, 0, '0, 1);
        #1;
        check("byp_wb_valid", bus.wb_valid, 1'b1);
        check("byp_wb_data", bus.wb_data, 32'hDEAD);
        check("byp_wb_dest", bus.wb_dest, 4'd2);
        check("byp_level", bus.level, 3'd0);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        #1;
        check("byp_after_level", bus.level, 3'd0);
        check("byp_after_wb_valid", bus.wb_valid, 1'b0);
`endif

        // randomized traffic against the reference model
        m_ccr = 5'b00000;
        model_q.delete();
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            drive($urandom_range(0, 99) < 70, N'($urandom), 5'($urandom_range(0, 31)),
                  5'($urandom_range(0, 31)), $urandom_range(0, 99) < 75,
                  REG_W'($urandom_range(0, 15)), $urandom_range(0, 99) < 10,
                  5'($urandom_range(0, 31)), $urandom_range(0, 99) < 50);
            #1;
            m_acc = bus.in_valid && (model_q.size() < DEPTH);
            m_byp = BYP && (model_q.size() == 0) && bus.wb_ready && m_acc && bus.in_WEN;
            check("rnd_in_ready", bus.in_ready, model_q.size() < DEPTH);
            check("rnd_level", bus.level, model_q.size());
            check("rnd_wb_valid", bus.wb_valid, (model_q.size() != 0) || m_byp);
            check("rnd_ccr", bus.out_CCR, m_ccr);
            check("rnd_out_x", bus.out_X, m_ccr[4]);
            if (model_q.size() != 0) begin
                check("rnd_wb_data", bus.wb_data, model_q[0].data);
                check("rnd_wb_dest", bus.wb_dest, model_q[0].dest);
            end
`ifdef ALU_WB_BYPASS_EN
            else if (m_byp) begin
                check("rnd_byp_data", bus.wb_data, bus.in_RES);
            end
`endif
            if (model_q.size() != 0 && bus.wb_ready) void'(model_q.pop_front());
            if (m_acc && bus.in_WEN && !m_byp) model_q.push_back('{bus.in_RES, bus.in_DEST});
            if (bus.ccr_load) begin
                m_ccr = bus.ccr_value;
            end else if (m_acc) begin
                for (int b = 0; b < 5; b++) if (bus.in_MASK[b]) m_ccr[b] = bus.in_XNZVC[b];
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_ccr_writeback.md
Name: alu_ccr_writeback

Overview:
- Consumer end of the ALU datapath.
- Accepts ALU results and XNZVC flags from the issue side over a valid/ready handshake.
- Merges the flags into the condition-code register (CCR) under a per-flag mask, and feeds CCR X back to the ALU `in_X`.
- Buffers register-destined results in a FIFO that drains to the register-file write port, which may stall.

Parameters:
- N, 32, result width (matches ALU N).
- DEPTH, 4, result FIFO entries; power of two, 2..16.
- REG_W, 4, destination register index width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  issue side presents a completed ALU op.
- in_ready  out  1  block can accept this cycle.
- in_RES  in  N  ALU result.
- in_XNZVC  in  5  ALU flags, bit order {X,N,Z,V,C}, X = bit 4 (bitpos_* in vcpu.vh).
- in_MASK  in  5  CCR bits this op updates, same bit order.
- in_WEN  in  1  result is written to a register (0 for compare/test ops).
- in_DEST  in  REG_W  destination register index.
- ccr_load  in  1  direct CCR write (move-to-CCR).
- ccr_value  in  5  value for ccr_load.
- out_CCR  out  5  current CCR.
- out_X  out  1  out_CCR[4]; drives ALU in_X.
- wb_valid  out  1  FIFO head valid.
- wb_ready  in  1  register file accepts head.
- wb_data  out  N  head result.
- wb_dest  out  REG_W  head destination.
- level  out  clog2(DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset (asynchronous, active-high):
  - CCR = 5'b00000; FIFO empty; level = 0; wb_valid = 0; wb_data and wb_dest = 0.
  - in_ready forced 0 while reset is high.
  - Reset mid-operation discards all FIFO contents.
- Accept:
  - `acc = in_valid & in_ready`.
  - `in_ready = ~reset & (level != DEPTH)`. in_ready does not depend on wb_ready (no combinational path).
  - Every transaction needs in_ready, including in_WEN=0, to preserve ordering.
- CCR update on rising edge with acc:
  - `CCR <= (CCR & ~in_MASK) | (in_XNZVC & in_MASK)`.
  - in_MASK = 0 leaves CCR unchanged.
- ccr_load wins over acc in the same cycle: `CCR <= ccr_value`. The accepted op's result is still pushed if in_WEN.
- X feedback latency:
  - Op accepted at edge k: out_X reflects it in the cycle after edge k.
  - Back-to-back dependent rotate-through-X ops therefore need no stall.
- FIFO:
  - Push when `acc & in_WEN`.
  - Pop when `wb_valid & wb_ready`.
  - Push and pop in the same cycle: level unchanged, order preserved.
  - Pop on empty: impossible (wb_valid = 0).
  - Push on full: impossible (in_ready = 0).
  - Read/write pointers wrap modulo DEPTH.
  - wb_data/wb_dest are the head entry, held stable while `wb_valid & ~wb_ready`.
- Latency: push at edge k makes wb_valid high in the cycle after edge k (1 cycle).
- Throughput: 1 op/cycle while not full.

Optional Feature:
- Macro: ALU_WB_BYPASS_EN.
- With the macro:
  - Condition: FIFO empty, wb_ready high, and `acc & in_WEN`.
  - Result: wb_valid, wb_data and wb_dest drive in_RES/in_DEST combinationally in the same cycle; the entry is not stored and level stays 0.
  - CCR behaviour is unchanged.
- Without the macro: always the 1-cycle FIFO latency; no combinational path from in_* to wb_*.

Test Plan:
- Reset then idle → CCR = 0, out_X = 0, wb_valid = 0, level = 0, in_ready = 1 after reset drops.
- Accept RES=0x000008FF, XNZVC=5'b10001, MASK=5'b11111, WEN=1, DEST=3, wb_ready=1 → next cycle: CCR = 5'b10001, out_X = 1, wb_valid = 1, wb_data = 0x8FF, wb_dest = 3; wb_valid = 0 the cycle after.
- CCR = 5'b10001, then accept XNZVC=5'b00100, MASK=5'b01111 (X untouched) → CCR = 5'b10100, out_X stays 1.
- wb_ready=0, push 5 ops with WEN=1 (RES 1..5), DEPTH=4 → in_ready = 0 after the 4th, level = 4; raise wb_ready → pops 1,2,3,4 in order, then 5 is accepted.
- Same cycle: ccr_load=1 with ccr_value=5'b01010, and acc with XNZVC=5'b11111, MASK=5'b11111, WEN=1 → CCR = 5'b01010, result still enters FIFO.
- Reset asserted with level = 3 → wb_valid and level drop to 0 immediately (asynchronous), CCR = 0.
- With ALU_WB_BYPASS_EN, empty FIFO, wb_ready=1, push RES=0xDEAD → wb_valid = 1, wb_data = 0xDEAD in the same cycle, level = 0.
